// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/address ops and a 32-iteration shift-add multiplier
// that stalls the upstream ID/EX slot while it runs.
module ex_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic [4:0]      rsd_i,
   input  logic [2:0]      Op_i,
   input  logic            valid_i,
   input  logic            flush_i,
   output logic [XLEN-1:0] result_o,
   output logic [XLEN-1:0] rs2_data_o,
   output logic [4:0]      rsd_o,
   output logic [2:0]      Op_o,
   output logic            valid_o,
   output logic            stall_o
);

   localparam int unsigned OP_W  = 3;
   localparam int unsigned RD_W  = 5;
   localparam int unsigned CNT_W = 5;

   localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
   localparam logic [OP_W-1:0] OP_AND  = 3'b010;
   localparam logic [OP_W-1:0] OP_OR   = 3'b011;
   localparam logic [OP_W-1:0] OP_MUL  = 3'b100;
   localparam logic [OP_W-1:0] OP_ADDI = 3'b101;
   localparam logic [OP_W-1:0] OP_LS   = 3'b110;

   typedef enum logic {IDLE, BUSY} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic [XLEN-1:0]   m_rs2_q, m_rs2_d;
   logic [RD_W-1:0]   m_rsd_q, m_rsd_d;
   logic [OP_W-1:0]   m_op_q, m_op_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic [XLEN-1:0]   rs2_q, rs2_d;
   logic [RD_W-1:0]   rsd_q, rsd_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic              valid_q, valid_d;
   logic [XLEN-1:0]   alu_res_c;
   logic [XLEN-1:0]   acc_step_c;

   // Single-cycle result; MUL and the reserved code both yield zero here
   always_comb begin
      alu_res_c = '0;
      case (Op_i)
         OP_ADD:         alu_res_c = rs1_data_i + rs2_data_i;
         OP_SUB:         alu_res_c = rs1_data_i - rs2_data_i;
         OP_AND:         alu_res_c = rs1_data_i & rs2_data_i;
         OP_OR:          alu_res_c = rs1_data_i | rs2_data_i;
         OP_ADDI, OP_LS: alu_res_c = rs1_data_i + imm_i;
         default:        alu_res_c = '0;
      endcase
   end

   assign acc_step_c = mplier_q[0] ? acc_q + mcand_q : acc_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      m_rs2_d  = m_rs2_q;
      m_rsd_d  = m_rsd_q;
      m_op_d   = m_op_q;
      result_d = result_q;
      rs2_d    = rs2_q;
      rsd_d    = rsd_q;
      op_d     = op_q;
      valid_d  = 1'b0;
      // Flush wins over everything, including a multiply finishing this edge
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  if (Op_i == OP_MUL) begin
                     mcand_d  = rs1_data_i;
                     mplier_d = rs2_data_i;
                     m_rs2_d  = rs2_data_i;
                     m_rsd_d  = rsd_i;
                     m_op_d   = Op_i;
                     acc_d    = '0;
                     cnt_d    = '0;
                     state_d  = BUSY;
                  end else begin
                     result_d = alu_res_c;
                     rs2_d    = rs2_data_i;
                     rsd_d    = rsd_i;
                     op_d     = Op_i;
                     valid_d  = 1'b1;
                  end
               end
            end
            BUSY: begin
               acc_d    = acc_step_c;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(31)) begin
                  state_d  = IDLE;
                  result_d = acc_step_c;
                  rs2_d    = m_rs2_q;
                  rsd_d    = m_rsd_q;
                  op_d     = m_op_q;
                  valid_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         m_rs2_q  <= '0;
         m_rsd_q  <= '0;
         m_op_q   <= '0;
         result_q <= '0;
         rs2_q    <= '0;
         rsd_q    <= '0;
         op_q     <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         m_rs2_q  <= m_rs2_d;
         m_rsd_q  <= m_rsd_d;
         m_op_q   <= m_op_d;
         result_q <= result_d;
         rs2_q    <= rs2_d;
         rsd_q    <= rsd_d;
         op_q     <= op_d;
         valid_q  <= valid_d;
      end
   end

   assign result_o   = result_q;
   assign rs2_data_o = rs2_q;
   assign rsd_o      = rsd_q;
   assign Op_o       = op_q;
   assign valid_o    = valid_q;
   assign stall_o    = (state_q == BUSY);

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: a stepping driver with a behavioural timing/result model
// pushes expected completions; a negedge monitor pops and compares them.
module tb_ex_stage;

   logic        clk;
   logic        rst_n;
   logic [31:0] rs1, rs2, imm;
   logic [4:0]  rsd;
   logic [2:0]  op;
   logic        valid_in, flush;
   logic [31:0] result_o, rs2_data_o;
   logic [4:0]  rsd_o;
   logic [2:0]  op_o;
   logic        valid_o, stall_o;

   ex_stage #(.XLEN(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .rs1_data_i(rs1), .rs2_data_i(rs2), .imm_i(imm), .rsd_i(rsd),
      .Op_i(op), .valid_i(valid_in), .flush_i(flush),
      .result_o(result_o), .rs2_data_o(rs2_data_o), .rsd_o(rsd_o),
      .Op_o(op_o), .valid_o(valid_o), .stall_o(stall_o)
   );

   typedef struct {
      logic [31:0] res;
      logic [31:0] rs2;
      logic [4:0]  rsd;
      logic [2:0]  op;
      int          edge_n;
   } exp_t;

   exp_t        q[$];
   exp_t        mul_exp;
   int          busy_cnt;
   int          cyc;
   int          n_chk;
   int          n_fail;
   logic [31:0] held_res;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] i);
      case (o)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a * b;
         3'd5:    return a + i;
         3'd6:    return a + i;
         default: return 32'd0;
      endcase
   endfunction

   // One cycle of upstream behaviour plus the model's prediction for the next rising edge
   task automatic step(input logic v, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] i, input logic [4:0] rd,
                       input logic fl);
      exp_t e;
      @(negedge clk);
      #1;
      chk("stall_o", {31'd0, stall_o}, {31'd0, busy_cnt > 0});
      valid_in = v; op = o; rs1 = a; rs2 = b; imm = i; rsd = rd; flush = fl;
      if (fl) begin
         busy_cnt = 0;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            mul_exp.edge_n = cyc + 1;
            q.push_back(mul_exp);
         end
      end else if (v) begin
         e.res = ref_res(o, a, b, i);
         e.rs2 = b; e.rsd = rd; e.op = o; e.edge_n = cyc + 1;
         if (o == 3'd4) begin
            busy_cnt = 32;
            mul_exp  = e;
         end else begin
            q.push_back(e);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_result_o", result_o, 32'd0);
      chk("rst_rs2_data_o", rs2_data_o, 32'd0);
      chk("rst_rsd_o", {27'd0, rsd_o}, 32'd0);
      chk("rst_op_o", {29'd0, op_o}, 32'd0);
      chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
      chk("rst_stall_o", {31'd0, stall_o}, 32'd0);
   endtask

   // Monitor: every cycle either a completion is due and matches, or outputs hold
   initial begin
      exp_t e;
      logic exp_v;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].edge_n < cyc) void'(q.pop_front());
         exp_v = (q.size() > 0 && q[0].edge_n == cyc);
         chk("valid_o", {31'd0, valid_o}, {31'd0, exp_v});
         if (exp_v) begin
            e = q.pop_front();
            chk("result_o", result_o, e.res);
            chk("rs2_data_o", rs2_data_o, e.rs2);
            chk("rsd_o", {27'd0, rsd_o}, {27'd0, e.rsd});
            chk("op_o", {29'd0, op_o}, {29'd0, e.op});
            held_res = e.res;
         end else begin
            chk("result_hold", result_o, held_res);
         end
      end
   end

   initial begin
      logic [31:0] pick [0:5];
      logic        v, fl;
      logic [2:0]  o;
      logic [31:0] a, b;
      n_chk = 0; n_fail = 0; cyc = 0; busy_cnt = 0; held_res = 32'd0;
      rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0;
      rs1 = '0; rs2 = '0; imm = '0; rsd = '0; op = '0;
      #1;
      check_reset_outputs();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 5'd3, 1'b0);
      step(1'b1, 3'd1, 32'd0, 32'd1, 32'd0, 5'd4, 1'b0);
      step(1'b1, 3'd6, 32'h100, 32'hCAFE_F00D, 32'hFFFF_FFFC, 5'd5, 1'b0);
      idle(1);

      // MUL with an ADD held behind it for the whole stall
      step(1'b1, 3'd4, 32'hFFFF_FFFF, 32'd3, 32'd0, 5'd6, 1'b0);
      for (int k = 0; k < 33; k++) step(1'b1, 3'd0, 32'd10, 32'd20, 32'd0, 5'd7, 1'b0);
      idle(1);

      step(1'b1, 3'd0, 32'd11, 32'd22, 32'd0, 5'd8, 1'b0);
      idle(3);
      step(1'b1, 3'd7, 32'h1234, 32'h5678, 32'h9, 5'd9, 1'b0);
      idle(1);

      // Flush on the iteration with count 10
      step(1'b1, 3'd4, 32'd123, 32'd456, 32'd0, 5'd10, 1'b0);
      idle(10);
      step(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b1);
      idle(40);

      // Asynchronous reset mid-multiply, away from any clock edge
      step(1'b1, 3'd4, 32'hDEAD_BEEF, 32'h1357_9BDF, 32'd0, 5'd11, 1'b0);
      idle(20);
      #1;
      rst_n = 1'b0; valid_in = 1'b0;
      busy_cnt = 0; q.delete(); held_res = 32'd0;
      #1;
      check_reset_outputs();
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      step(1'b1, 3'd0, 32'd2, 32'd3, 32'd0, 5'd12, 1'b0);
      idle(1);

      pick[0] = 32'd0; pick[1] = 32'hFFFF_FFFF; pick[2] = 32'h8000_0000;
      pick[3] = 32'h7FFF_FFFF; pick[4] = 32'd1; pick[5] = 32'd0;
      for (int n = 0; n < 700; n++) begin
         v  = ($urandom_range(0, 3) != 0);
         fl = ($urandom_range(0, 39) == 0);
         o  = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
         step(v, o, a, b, $urandom, 5'($urandom_range(0, 31)), fl);
      end
      idle(40);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
